// File: rtl/keypad_scan_debounce_pkg.sv
// Shared constants, FSM encoding and key map for the keypad scanner.
package keypad_scan_debounce_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  // Active-low one-hot row drive patterns
  localparam logic [3:0] ROW0 = 4'b1110;
  localparam logic [3:0] ROW1 = 4'b1101;
  localparam logic [3:0] ROW2 = 4'b1011;
  localparam logic [3:0] ROW3 = 4'b0111;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPress   = 2'd1,
    StHeld    = 2'd2,
    StRelease = 2'd3
  } state_e;

  // Rows 0-2 carry digits 1-9 in reading order; row 3 is *, 0, #.
  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    if (row_idx != 2'd3) begin
      code = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
    end else begin
      unique case (col_idx)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        2'd2:    code = KEY_HASH;
        default: code = KEY_NONE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Keypad matrix lines plus the debounced key outputs.
interface keypad_scan_debounce_if;

  logic [2:0] cols;
  logic [3:0] rows;
  logic [3:0] keycode;
  logic       key_valid;
  logic       key_held;

  // master: the scanner; slave: keypad matrix and key consumer
  modport master (input cols, output rows, output keycode, output key_valid, output key_held);
  modport slave (output cols, input rows, input keycode, input key_valid, input key_held);

endinterface

// File: rtl/keypad_scan_decode.sv
// Combinational decode of one row slot: which key (if any) and whether several columns are low.
module keypad_scan_decode
  import keypad_scan_debounce_pkg::*;
(
  input  logic [3:0] rows,
  input  logic [2:0] cols,
  output logic [3:0] code,
  output logic       hit,
  output logic       multi
);

  logic       row_ok;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic [2:0] low;
  logic [1:0] n_low;

  // Map the driven row to an index and count the pulled-down columns
  always_comb begin
    row_ok  = 1'b1;
    row_idx = 2'd0;
    unique case (rows)
      ROW0:    row_idx = 2'd0;
      ROW1:    row_idx = 2'd1;
      ROW2:    row_idx = 2'd2;
      ROW3:    row_idx = 2'd3;
      default: row_ok  = 1'b0;
    endcase

    low     = ~cols;
    n_low   = {1'b0, low[0]} + {1'b0, low[1]} + {1'b0, low[2]};
    col_idx = low[0] ? 2'd0 : (low[1] ? 2'd1 : 2'd2);

    // A corrupted row pattern contributes nothing to the scan
    hit   = row_ok && (n_low != 2'd0);
    multi = row_ok && (n_low > 2'd1);
    code  = hit ? key_map(row_idx, col_idx) : KEY_NONE;
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x3 keypad row scanner with multi-scan debounce and one-cycle key_valid strobe.
module keypad_scan_debounce
  import keypad_scan_debounce_pkg::*;
#(
  parameter int unsigned SCAN_TICKS   = 50000,
  parameter int unsigned STABLE_SCANS = 20
) (
  input logic                     CLOCK_50,
  input logic                     reset,
  keypad_scan_debounce_if.master  bus
);

  localparam int unsigned SlotW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned CntW  = $clog2(STABLE_SCANS + 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_TICKS - 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(STABLE_SCANS);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);

  logic [SlotW-1:0] slot_q;
  logic [3:0]       rows_q;
  logic [3:0]       acc_code_q;
  logic             acc_hit_q;
  logic             acc_multi_q;

  logic [3:0] slot_code;
  logic       slot_hit;
  logic       slot_multi;

  logic       tick;
  logic       scan_end;
  logic [3:0] rows_next;
  logic [3:0] res_code;
  logic       res_hit;
  logic       res_multi;
  logic       res_single;
  logic       res_none;

  state_e          state_q;
  logic [3:0]      cand_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic [3:0]      keycode_q;
  logic            key_valid_q;
  logic            key_held_q;

  keypad_scan_decode u_decode (
    .rows  (rows_q),
    .cols  (bus.cols),
    .code  (slot_code),
    .hit   (slot_hit),
    .multi (slot_multi)
  );

  // Slot timing, next row pattern and the scan result including the current slot
  always_comb begin
    tick     = (slot_q == SlotLast);
    scan_end = tick && (rows_q == ROW3);

    unique case (rows_q)
      ROW0:    rows_next = ROW1;
      ROW1:    rows_next = ROW2;
      ROW2:    rows_next = ROW3;
      default: rows_next = ROW0;
    endcase

    // Two hits in different slots is a ghost/multi-key, same as two low columns in one slot
    res_hit    = acc_hit_q | slot_hit;
    res_multi  = acc_multi_q | slot_multi | (acc_hit_q & slot_hit);
    res_code   = slot_hit ? slot_code : acc_code_q;
    res_single = res_hit && !res_multi;
    res_none   = !res_hit && !res_multi;

    cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
  end

  // Slot counter, row drive and per-scan accumulator
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      slot_q      <= '0;
      rows_q      <= ROW0;
      acc_code_q  <= KEY_NONE;
      acc_hit_q   <= 1'b0;
      acc_multi_q <= 1'b0;
    end else if (tick) begin
      slot_q <= '0;
      rows_q <= rows_next;
      if (scan_end) begin
        acc_code_q  <= KEY_NONE;
        acc_hit_q   <= 1'b0;
        acc_multi_q <= 1'b0;
      end else begin
        acc_code_q  <= res_code;
        acc_hit_q   <= res_hit;
        acc_multi_q <= res_multi;
      end
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  // Debounce FSM with registered outputs, stepped once per full scan
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= StIdle;
      cand_q      <= KEY_NONE;
      cnt_q       <= '0;
      keycode_q   <= KEY_NONE;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_end) begin
        unique case (state_q)
          StIdle: begin
            if (res_single) begin
              state_q <= StPress;
              cand_q  <= res_code;
              cnt_q   <= CntOne;
            end
          end
          StPress: begin
            if (res_single && (res_code == cand_q)) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CntMax) begin
                state_q     <= StHeld;
                keycode_q   <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end
            end else if (res_single) begin
              cand_q <= res_code;
              cnt_q  <= CntOne;
            end else begin
              state_q <= StIdle;
            end
          end
          StHeld: begin
            // Rollover to another key while held is ignored until a clean release
            if (res_none) begin
              state_q <= StRelease;
              cnt_q   <= CntOne;
            end
          end
          StRelease: begin
            if (res_none) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CntMax) begin
                state_q    <= StIdle;
                key_held_q <= 1'b0;
              end
            end else begin
              state_q <= StHeld;
            end
          end
          default: begin
            state_q    <= StIdle;
            key_held_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rows      = rows_q;
  assign bus.keycode   = keycode_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;

endmodule
